memory_ctrl: RTL and testbench
==============================

// Module: memory_ctrl
// PURPOSE
//  Parametrised single-port synchronous RAM; next generation of the 4x16 lab memory.
//  - Adds: registered read with a valid strobe, a selectable read-during-write mode,
//    and a hardware clear sequencer that writes INIT_VAL to every word after reset.
//  - Sits between datapath/FSM lab blocks and storage; the same CLK drives all logic.
// PARAMETERS
//  DATA_W      4   data word width (bits)
//  ADDR_W      4   address width; depth DEPTH = 2**ADDR_W (localparam)
//  INIT_VAL    0   value written to every word by the clear sequencer (DATA_W bits)
//  WRITE_FIRST 1   1: simultaneous WR&RD returns new data; 0: returns old data
// PORTS
//  CLK    in   1       clock, all logic on rising edge
//  RST    in   1       synchronous reset, active-high
//  WR     in   1       write request, sampled at CLK edge
//  RD     in   1       read request, sampled at CLK edge
//  A      in   ADDR_W  word address for WR/RD
//  D_IN   in   DATA_W  write data
//  Q      out  DATA_W  registered read data
//  Q_VAL  out  1       1-cycle strobe: Q updated by a read at the previous edge
//  BUSY   out  1       clear sequencer running; WR/RD are ignored
//  ERR    out  1       1-cycle strobe: WR or RD asserted while BUSY
// BEHAVIOUR
//  Reset (RST=1 at edge): state<=CLEAR, cnt<=0, Q<=0, Q_VAL<=0, BUSY<=1, ERR<=0.
//   - RST overrides all inputs; memory is not written on the reset edge.
//  FSM states: CLEAR, READY.
//  CLEAR: each edge with RST=0 writes mem[cnt]<=INIT_VAL, cnt<=cnt+1.
//   - Edge that writes cnt=DEPTH-1 sets state<=READY, BUSY<=0 (cnt wraps to 0).
//   - BUSY is therefore high for exactly DEPTH edges after RST deasserts.
//   - WR or RD high at an edge in CLEAR: request dropped, ERR<=1 for one cycle.
//   - Q and Q_VAL stay 0 in CLEAR.
//  READY, per edge:
//   - WR=1,RD=0: mem[A]<=D_IN; Q holds; Q_VAL<=0.
//   - WR=0,RD=1: Q<=mem[A]; Q_VAL<=1. Read latency is 1 cycle.
//   - WR=1,RD=1: mem[A]<=D_IN; Q<=D_IN if WRITE_FIRST=1, else old mem[A]; Q_VAL<=1.
//   - WR=0,RD=0: Q holds its last value; Q_VAL<=0.
//   - ERR<=0.
//  Back-to-back reads at different addresses give one result per cycle, Q_VAL high.
//   - A write at edge n followed by a read of the same A at edge n+1 returns the new data.
//  Address covers the full 2**ADDR_W range; no out-of-range case exists.
//  Reset mid-operation (either state): returns to CLEAR with cnt=0; the whole array
//   is re-cleared; any in-flight Q_VAL is dropped.
//  Outputs are registered only; no combinational path from inputs to Q/Q_VAL/BUSY/ERR.
// TESTING (defaults unless noted)
//  1 Reset then wait: RST 1 for 2 cycles, then 0 -> BUSY=1 for 16 edges, then 0.
//    Reading all 16 addresses then gives Q=4'h0, with Q_VAL=1 for each read.
//  2 Write/read: WR A=3 D=9, WR A=13 D=10, RD A=3, RD A=13
//    -> Q=9 then Q=10 on consecutive cycles, Q_VAL=1 on both.
//  3 Read-during-write: mem[5]=2, then WR=RD=1, A=5, D_IN=7
//    -> Q=7 when WRITE_FIRST=1, Q=2 when WRITE_FIRST=0; mem[5]=7 in both cases.
//  4 Request while BUSY: WR A=1 D=15 on the 3rd clear cycle -> ERR=1 for one cycle.
//    A later read of A=1 returns 0.
//  5 Mid-op reset: fill mem[0..15]=i, RST for 1 cycle during a read
//    -> Q=0, Q_VAL=0, BUSY=1 for 16 edges, and all words read back as 0.
//  6 Params DATA_W=8, ADDR_W=6, INIT_VAL=8'hA5 -> BUSY lasts 64 edges.
//    Every word then reads back as A5; a write/read of 8'h3C at A=63 returns 3C.

Source files
------------

// File: rtl/memory_ctrl.sv
// Single-port synchronous RAM with registered read, selectable read-during-write
// behaviour and a sequencer that clears every word to INIT_VAL after reset.
module memory_ctrl #(
  parameter int                 DATA_W      = 4,
  parameter int                 ADDR_W      = 4,
  parameter logic [DATA_W-1:0]  INIT_VAL    = '0,
  parameter bit                 WRITE_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR,
  input  logic              RD,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D_IN,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VAL,
  output logic              BUSY,
  output logic              ERR
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   cnt_d;
  logic [DATA_W-1:0]   q_q;
  logic                q_val_q;
  logic                busy_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  assign cnt_d = cnt_q + 1'b1;

  // The clear sequencer owns the write port while in CLEAR; the reset edge never writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = A;
    mem_wdata = D_IN;
    if (!RST) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = INIT_VAL;
      end else begin
        mem_we    = WR;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      q_q     <= '0;
      q_val_q <= 1'b0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q   <= cnt_d;
          q_val_q <= 1'b0;
          err_q   <= WR | RD;
          if (cnt_q == LAST_IDX) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          err_q   <= 1'b0;
          q_val_q <= RD;
          if (RD) begin
            // The array read sees the pre-edge contents, which gives read-first for free.
            if (WR && WRITE_FIRST) begin
              q_q <= D_IN;
            end else begin
              q_q <= mem_q[A];
            end
          end
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign Q     = q_q;
  assign Q_VAL = q_val_q;
  assign BUSY  = busy_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench: default instance, a read-first instance sharing its stimulus,
// and a wide 8x64 instance with INIT_VAL 8'hA5.
module tb_memory_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr, rd;
  logic [3:0] a, d_in;
  logic [3:0] q, q_rf;
  logic       q_val, q_val_rf, busy, busy_rf, err, err_rf;

  logic       rst_w, wr_w, rd_w;
  logic [5:0] a_w;
  logic [7:0] d_in_w, q_w;
  logic       q_val_w, busy_w, err_w;

  int checks = 0;
  int errors = 0;
  int n;

  memory_ctrl dut (
    .CLK(clk), .RST(rst), .WR(wr), .RD(rd), .A(a), .D_IN(d_in),
    .Q(q), .Q_VAL(q_val), .BUSY(busy), .ERR(err)
  );

  memory_ctrl #(.WRITE_FIRST(1'b0)) dut_rf (
    .CLK(clk), .RST(rst), .WR(wr), .RD(rd), .A(a), .D_IN(d_in),
    .Q(q_rf), .Q_VAL(q_val_rf), .BUSY(busy_rf), .ERR(err_rf)
  );

  memory_ctrl #(.DATA_W(8), .ADDR_W(6), .INIT_VAL(8'hA5)) dut_w (
    .CLK(clk), .RST(rst_w), .WR(wr_w), .RD(rd_w), .A(a_w), .D_IN(d_in_w),
    .Q(q_w), .Q_VAL(q_val_w), .BUSY(busy_w), .ERR(err_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic w, input logic r, input logic [3:0] addr, input logic [3:0] dat);
    wr = w; rd = r; a = addr; d_in = dat;
    tick();
  endtask

  task automatic op_w(input logic w, input logic r, input logic [5:0] addr, input logic [7:0] dat);
    wr_w = w; rd_w = r; a_w = addr; d_in_w = dat;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr = 0; rd = 0; a = 0; d_in = 0;
    rst_w = 1'b1; wr_w = 0; rd_w = 0; a_w = 0; d_in_w = 0;

    // 1: reset, clear duration, all words cleared
    tick(); tick();
    chk("rst_q", q, 4'h0);
    chk("rst_qval", q_val, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("clear_edges", n, 16);
    for (int i = 0; i < 16; i++) begin
      op(0, 1, 4'(i), 0);
      chk($sformatf("clr_rd%0d_q", i), q, 4'h0);
      chk($sformatf("clr_rd%0d_qval", i), q_val, 1'b1);
    end
    op(0, 0, 0, 0);
    chk("idle_qval", q_val, 1'b0);
    chk("idle_err", err, 1'b0);

    // 2: write/read, back-to-back reads
    op(1, 0, 4'd3, 4'd9);
    chk("wr3_qval", q_val, 1'b0);
    op(1, 0, 4'd13, 4'd10);
    op(0, 1, 4'd3, 0);
    chk("rd3_q", q, 4'd9);
    chk("rd3_qval", q_val, 1'b1);
    op(0, 1, 4'd13, 0);
    chk("rd13_q", q, 4'd10);
    chk("rd13_qval", q_val, 1'b1);
    op(0, 0, 0, 0);
    chk("hold_q", q, 4'd10);
    chk("hold_qval", q_val, 1'b0);

    // 3: read-during-write in both modes
    op(1, 0, 4'd5, 4'd2);
    op(1, 1, 4'd5, 4'd7);
    chk("rdw_wf_q", q, 4'd7);
    chk("rdw_rf_q", q_rf, 4'd2);
    chk("rdw_wf_qval", q_val, 1'b1);
    chk("rdw_rf_qval", q_val_rf, 1'b1);
    op(0, 1, 4'd5, 0);
    chk("rdw_wf_mem", q, 4'd7);
    chk("rdw_rf_mem", q_rf, 4'd7);

    // 4: write request while clearing
    rst = 1'b1; op(0, 0, 0, 0);
    rst = 1'b0;
    op(0, 0, 0, 0);
    op(0, 0, 0, 0);
    chk("busy_pre_err", busy, 1'b1);
    op(1, 0, 4'd1, 4'd15);
    chk("err_set", err, 1'b1);
    wr = 0;
    tick();
    chk("err_clr", err, 1'b0);
    n = 4;
    while (busy && n < 200) begin tick(); n++; end
    chk("clear2_edges", n, 16);
    op(0, 1, 4'd1, 0);
    chk("busy_wr_dropped", q, 4'h0);
    chk("busy_wr_qval", q_val, 1'b1);

    // 5: reset with a read in flight
    for (int i = 0; i < 16; i++) op(1, 0, 4'(i), 4'(i));
    op(0, 1, 4'd7, 0);
    chk("fill_rd7", q, 4'd7);
    rst = 1'b1; op(0, 1, 4'd9, 0);
    chk("midrst_q", q, 4'h0);
    chk("midrst_qval", q_val, 1'b0);
    chk("midrst_busy", busy, 1'b1);
    rst = 1'b0; rd = 0;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("clear3_edges", n, 16);
    for (int i = 0; i < 16; i++) begin
      op(0, 1, 4'(i), 0);
      chk($sformatf("reclr_rd%0d", i), q, 4'h0);
    end
    op(0, 0, 0, 0);

    // 6: wide instance
    chk("w_rst_busy", busy_w, 1'b1);
    chk("w_rst_q", q_w, 8'h00);
    rst_w = 1'b0;
    n = 0;
    while (busy_w && n < 400) begin tick(); n++; end
    chk("w_clear_edges", n, 64);
    for (int i = 0; i < 64; i++) begin
      op_w(0, 1, 6'(i), 0);
      chk($sformatf("w_rd%0d", i), q_w, 8'hA5);
    end
    op_w(1, 0, 6'd63, 8'h3C);
    chk("w_wr_qval", q_val_w, 1'b0);
    op_w(0, 1, 6'd63, 0);
    chk("w_rd63_q", q_w, 8'h3C);
    chk("w_rd63_qval", q_val_w, 1'b1);
    op_w(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
